// File: rtl/gpo_blink.sv
// gpo_blink: general-purpose output slot with atomic set/clear/toggle
// access and a free-running blink engine that gates selected bits.
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-low reset
//   cs       slot chip select
//   read     read strobe (reads have no side effects)
//   write    write strobe, effective when cs && write
//   addr     register index
//   wr_data  write data, bits above W ignored
//   rd_data  combinational read data, zero-extended
//   data_out registered output pins
module gpo_blink #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cs,
    input  logic         read,
    input  logic         write,
    input  logic [4:0]   addr,
    input  logic [31:0]  wr_data,
    output logic [31:0]  rd_data,
    output logic [W-1:0] data_out
);

    localparam logic [4:0] A_DATA   = 5'd0;
    localparam logic [4:0] A_SET    = 5'd1;
    localparam logic [4:0] A_CLR    = 5'd2;
    localparam logic [4:0] A_TGL    = 5'd3;
    localparam logic [4:0] A_BEN    = 5'd4;
    localparam logic [4:0] A_PERIOD = 5'd5;
    localparam logic [4:0] A_STATUS = 5'd6;

    logic [W-1:0] data_reg;
    logic [W-1:0] data_nxt;
    logic [W-1:0] blink_en;
    logic [31:0]  period;
    logic [31:0]  cnt;
    logic         phase;

    logic         we;
    logic [W-1:0] wdat;
    logic         period_wr;
    logic         expire;
    logic         unused_ok;

    assign we        = cs & write;
    assign wdat      = wr_data[W-1:0];
    assign period_wr = we && (addr == A_PERIOD);
    assign expire    = (period != 32'd0) && (cnt == period - 32'd1);

    // Strobe and high write bits carry no information for this core.
    assign unused_ok = ^{read, wr_data};

    always_comb begin
        data_nxt = data_reg;
        if (we) begin
            unique case (addr)
                A_DATA:  data_nxt = wdat;
                A_SET:   data_nxt = data_reg | wdat;
                A_CLR:   data_nxt = data_reg & ~wdat;
                A_TGL:   data_nxt = data_reg ^ wdat;
                default: data_nxt = data_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_reg <= '0;
        end else begin
            data_reg <= data_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_en <= '0;
        end else if (we && (addr == A_BEN)) begin
            blink_en <= wdat;
        end
    end

    // A period write restarts the half-period with phase high and
    // wins over an expiry landing on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period <= 32'd0;
            cnt    <= 32'd0;
            phase  <= 1'b1;
        end else if (period_wr) begin
            period <= wr_data;
            cnt    <= 32'd0;
            phase  <= 1'b1;
        end else if (period == 32'd0) begin
            cnt    <= 32'd0;
            phase  <= 1'b1;
        end else if (expire) begin
            cnt    <= 32'd0;
            phase  <= ~phase;
        end else begin
            cnt    <= cnt + 32'd1;
        end
    end

    // Blinking bits are forced low during the low phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out <= '0;
        end else begin
            data_out <= (data_reg & ~blink_en)
                      | (data_reg & blink_en & {W{phase}});
        end
    end

    always_comb begin
        rd_data = 32'd0;
        unique case (addr)
            A_DATA:   rd_data = 32'(data_reg);
            A_BEN:    rd_data = 32'(blink_en);
            A_PERIOD: rd_data = period;
            A_STATUS: rd_data = {31'd0, phase};
            default:  rd_data = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_gpo_blink.sv
// tb_gpo_blink: directed vectors for gpo_blink (W=8), register
// access, blink timing, period rewrite and asynchronous reset.
module tb_gpo_blink;

    logic        clk;
    logic        reset;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic [7:0]  data_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        logic [7:0]  exp;
    } vec_t;

    vec_t vt[6];

    gpo_blink #(.W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .cs       (cs),
        .read     (read),
        .write    (write),
        .addr     (addr),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cs = 1'b1;
        write = 1'b1;
        addr = a;
        wr_data = d;
        tick();
        cs = 1'b0;
        write = 1'b0;
        wr_data = 32'd0;
    endtask

    task automatic rd(input string nm, input logic [4:0] a,
                      input logic [31:0] exp);
        addr = a;
        read = 1'b1;
        #1;
        chk(nm, rd_data, exp);
        read = 1'b0;
    endtask

    initial begin
        vt[0] = '{5'd0, 32'h0000_00A5, 8'hA5};
        vt[1] = '{5'd1, 32'h0000_000F, 8'hAF};
        vt[2] = '{5'd2, 32'h0000_0081, 8'h2E};
        vt[3] = '{5'd3, 32'h0000_00FF, 8'hD1};
        vt[4] = '{5'd0, 32'hFFFF_FF3C, 8'h3C};
        vt[5] = '{5'd9, 32'h0000_00FF, 8'h3C};

        reset = 1'b0;
        cs = 1'b0;
        read = 1'b0;
        write = 1'b0;
        addr = 5'd0;
        wr_data = 32'd0;
        repeat (3) tick();
        reset = 1'b1;
        tick();

        chk("reset data_out", {24'd0, data_out}, 32'h0);
        rd("reset status", 5'd6, 32'h1);
        rd("reset data", 5'd0, 32'h0);
        rd("reset period", 5'd5, 32'h0);

        for (int i = 0; i < 6; i++) begin
            wr(vt[i].a, vt[i].d);
            rd($sformatf("vec%0d data", i), 5'd0, {24'd0, vt[i].exp});
            tick();
            chk($sformatf("vec%0d out", i), {24'd0, data_out},
                {24'd0, vt[i].exp});
        end

        rd("read set", 5'd1, 32'h0);
        rd("read addr9", 5'd9, 32'h0);

        cs = 1'b0;
        write = 1'b1;
        addr = 5'd0;
        wr_data = 32'h55;
        tick();
        write = 1'b0;
        rd("cs0 ignored", 5'd0, 32'h3C);

        // Blink: period write lands at edge E0, phase high from E0.
        wr(5'd0, 32'hFF);
        wr(5'd4, 32'h0F);
        wr(5'd5, 32'd4);
        rd("blink status0", 5'd6, 32'h1);
        chk("blink out0", {24'd0, data_out}, 32'hFF);
        for (int i = 1; i <= 20; i++) begin
            logic [7:0] eo;
            logic       ep;
            tick();
            eo = (((i - 1) / 4) % 2 == 0) ? 8'hFF : 8'hF0;
            ep = ((i / 4) % 2 == 0);
            chk($sformatf("blink out%0d", i), {24'd0, data_out},
                {24'd0, eo});
            rd($sformatf("blink ph%0d", i), 5'd6, {31'd0, ep});
        end

        // Rewrite period exactly when cnt == 3.
        wr(5'd5, 32'd4);
        repeat (3) tick();
        wr(5'd5, 32'd3);
        rd("rewrite no toggle", 5'd6, 32'h1);
        tick();
        rd("rewrite +1", 5'd6, 32'h1);
        tick();
        rd("rewrite +2", 5'd6, 32'h1);
        tick();
        rd("rewrite +3", 5'd6, 32'h0);

        wr(5'd5, 32'd0);
        rd("freeze ph", 5'd6, 32'h1);
        repeat (5) tick();
        rd("freeze hold", 5'd6, 32'h1);
        tick();
        chk("freeze out", {24'd0, data_out}, 32'hFF);

        wr(5'd5, 32'hFFFF_FFFF);
        rd("max period", 5'd5, 32'hFFFF_FFFF);
        repeat (4) tick();
        rd("max period ph", 5'd6, 32'h1);

        // Reset mid-blink while phase low.
        wr(5'd5, 32'd4);
        repeat (5) tick();
        rd("pre-reset ph", 5'd6, 32'h0);
        chk("pre-reset out", {24'd0, data_out}, 32'hF0);
        addr = 5'd6;
        #1;
        reset = 1'b0;
        #1;
        chk("async out", {24'd0, data_out}, 32'h0);
        chk("async status", rd_data, 32'h1);
        rd("async data", 5'd0, 32'h0);
        rd("async ben", 5'd4, 32'h0);
        tick();
        reset = 1'b1;
        tick();
        chk("post-reset out", {24'd0, data_out}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpo_blink.md
# gpo_blink

General-purpose output slot core: the output-side counterpart of the switch-input slot in the SoC I/O subsystem. It holds a W-bit output register that the processor writes through the standard slot bus, with atomic set/clear/toggle access. A programmable blink engine can gate selected bits with a free-running phase, so LEDs blink without software polling. The outputs are registered and drive external pins, such as LEDs.

## Interface
- W, default 8: number of output bits (1..32).
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- cs  input  1  slot chip select.
- read  input  1  read strobe; informational only, since reads have no side effects.
- write  input  1  write strobe; a write takes effect only when cs && write.
- addr  input  5  register index within the core.
- wr_data  input  32  write data; bits [31:W] are ignored for W-bit registers.
- rd_data  output  32  read data, decoded combinationally from addr; unused bits are 0.
- data_out  output  W  registered output pins.

## Operation
Register map (addr), with W-bit fields zero-extended on read:
- 0 DATA (R/W): data_reg <= wr_data[W-1:0].
- 1 SET (W): data_reg <= data_reg | wr_data[W-1:0]. Reads return 0.
- 2 CLR (W): data_reg <= data_reg & ~wr_data[W-1:0]. Reads return 0.
- 3 TOGGLE (W): data_reg <= data_reg ^ wr_data[W-1:0]. Reads return 0.
- 4 BLINK_EN (R/W): per-bit blink mask, blink_en.
- 5 BLINK_PERIOD (R/W): 32-bit half-period in clk cycles.
- 6 STATUS (R): bit0 = phase. All other bits are 0.
- Addresses 7..31: writes are ignored and reads return 0.

Blink engine:
- State: a 32-bit counter cnt and a 1-bit phase.
- If period == 0: cnt is held at 0 and phase is held at 1.
- If period != 0: each cycle, if cnt == period-1, then cnt <= 0 and phase <= ~phase; otherwise cnt <= cnt+1.
- A write to BLINK_PERIOD loads the new period, forces cnt <= 0 and forces phase <= 1. This has priority over expiry in the same cycle.

Output function, registered every cycle:
- data_out[i] <= blink_en[i] ? (data_reg[i] & phase) : data_reg[i].

Reset values, applied immediately on reset low, independent of clk:
- data_reg = 0, blink_en = 0, period = 0, cnt = 0, phase = 1, data_out = 0.
- rd_data reflects the reset register values.

## Timing
- A write presented before clock edge k updates its register at edge k. The dependent data_out changes at edge k+1, giving 1 cycle of output latency after the register update.
- rd_data is combinational from addr and the current register state. A read in the same cycle as a write to the same register returns the old value.
- With period = P > 0, phase toggles every P cycles, so a blinking bit has a full period of 2P cycles. With P = 1, phase toggles every cycle.
- The expiry toggle is visible on data_out one cycle after the phase toggles.
- Back-to-back writes on consecutive cycles are each applied in order; there are no stall cycles.
- Changing BLINK_EN or DATA mid-blink does not disturb cnt or phase.
- If reset asserts mid-blink, all state returns to its reset values. After reset deasserts, the first rising edge resumes normal operation.
- period = 0xFFFFFFFF is legal: cnt reaches 0xFFFFFFFE and then wraps to 0 with no overflow.

## Test plan
- Reset: hold reset low for 3 cycles, then release. Required: data_out = 0x00, STATUS = 0x1, and reads of DATA and BLINK_PERIOD return 0.
- Atomic ops (W=8):
  - Write DATA = 0xA5, then SET 0x0F, then CLR 0x81, then TOGGLE 0xFF.
  - DATA must read 0xA5, then 0xAF, then 0x2E, then 0xD1.
  - data_out must follow each value one cycle after the register update.
- Width and decode:
  - Write DATA = 0xFFFF_FF3C. DATA must read 0x0000_003C.
  - A write to addr 9 must change nothing. Reads of addr 1 and addr 9 must return 0.
  - A write with cs = 0 must be ignored.
- Blink (DATA = 0xFF, BLINK_EN = 0x0F, period = 4):
  - data_out must alternate between 0xFF and 0xF0.
  - Each level must last exactly 4 cycles.
  - Bits [7:4] must stay at 1 throughout.
- Period rewrite at expiry:
  - Write period = 3 in exactly the cycle where cnt == period-1.
  - Required: phase stays 1 (no toggle), then the next toggle occurs 3 cycles later.
  - A subsequent write of period = 0 must freeze phase at 1.
- Reset mid-blink: assert reset while phase = 0 and data_out = 0xF0. data_out must go to 0x00 and STATUS to 0x1 without waiting for a clock edge.
